count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Controller that shares one WIDTH-bit up-counter datapath between two requesters.
//  Each requester asks for a count run of a programmed length.
//  A round-robin arbiter grants the counter to one requester at a time.
//  The FSM then sequences the run IDLE -> RUN -> DONE and pulses a per-requester completion flag.
//  Sits between the counter datapath and the blocks that need timed count windows.
// PARAMETERS
//  WIDTH  4  counter and length width in bits; terminal value is 2**WIDTH-1
// PORTS
//  clk     in   1      single clock; all state updates on posedge clk
//  reset   in   1      synchronous, active-high; sampled on posedge clk
//  req     in   2      req[i]=1: requester i wants a run; level, sampled only in IDLE
//  len0    in   WIDTH  run length for requester 0; latched at grant
//  len1    in   WIDTH  run length for requester 1; latched at grant
//  gnt     out  2      one-hot owner of the counter; 2'b00 when idle
//  busy    out  1      1 in RUN and DONE states
//  count   out  WIDTH  counter datapath value
//  done    out  2      one-cycle pulse on done[i] when requester i's run completes
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset:
//    - Sampled high at a posedge: state=IDLE, gnt=0, busy=0, count=0, done=0, len_q=0, last=1.
//    - Takes effect at any point, including mid-run; the aborted run gives no done pulse.
//  - Arbitration (IDLE only, evaluated at each posedge):
//    - One req high: grant it.
//    - Both high: grant the requester that is not last (the last-served index).
//    - After reset, last=1, so req0 wins the first contention.
//    - No req: stay IDLE.
//  - Grant edge:
//    - state<=RUN, gnt<=onehot(i), busy<=1, count<=0.
//    - len_q<=len_i; last<=i.
//  - RUN, at each posedge:
//    - count==len_q: state<=DONE, done[i]<=1, count holds.
//    - Otherwise: count<=count+1.
//  - DONE (exactly one cycle):
//    - At the next posedge: state<=IDLE, gnt<=0, busy<=0, done<=0.
//    - count holds its final value until the next grant.
//  - Latency:
//    - gnt rises 1 cycle after req is sampled in IDLE.
//    - busy is high for len+2 cycles.
//    - done is high in the last busy cycle.
//    - At least one IDLE cycle separates consecutive grants.
//  - Boundaries:
//    - len=0: RUN lasts 1 cycle with count=0, then DONE.
//    - len=2**WIDTH-1: count reaches the max value and never wraps.
//    - req changes during RUN/DONE are ignored; a run always completes once granted.
//    - len0/len1 changes after the grant are ignored (len_q is used).
//    - req still high in IDLE after done: treated as a new request.
//    - Reset and req in the same cycle: reset wins, no grant.
// TESTING
//  1. Single run, len0=3:
//     - Stimulus: reset high 4 cycles, then req=01.
//     - Response: gnt=01 one cycle later; count 0,1,2,3,3; done=01 in the 5th busy cycle; then gnt=00.
//  2. Contention, len0=len1=2:
//     - Stimulus: req=11 held.
//     - Response: grants alternate 01,10,01,...; each run is 4 busy cycles plus 1 IDLE gap.
//  3. Zero length, len1=0:
//     - Stimulus: req=10.
//     - Response: busy for 2 cycles; count=0 throughout; done=10 in the 2nd cycle.
//  4. Max length, len0=15 (WIDTH=4):
//     - Stimulus: req=01.
//     - Response: count runs 0..15, holds 15, no wrap to 0; busy for 17 cycles.
//  5. Reset mid-run:
//     - Stimulus: reset asserted at count=5 during a req0 run with len0=9.
//     - Response: next cycle all outputs are 0 and no done pulse occurs; after release with req=11, gnt=01.
//  6. Request dropped mid-run:
//     - Stimulus: req0 falls at count=1 (len0=4).
//     - Response: run continues to count=4; done=01 pulses; then the FSM returns to IDLE.

Source files
------------

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//   Shares one WIDTH-bit up-counter between two requesters. A round-robin
//   arbiter picks an owner while idle. The FSM then runs the counter from 0 up
//   to the owner's latched length, holds for one DONE cycle with a completion
//   pulse, and returns to IDLE. Every output comes straight from a flop.
//
// Ports
//   clk    in   1      clock, all state on posedge
//   reset  in   1      synchronous, active-high
//   req    in   2      per-requester run request (level, sampled in IDLE only)
//   len0   in   WIDTH  run length for requester 0, latched at grant
//   len1   in   WIDTH  run length for requester 1, latched at grant
//   gnt    out  2      one-hot current owner, 0 when idle
//   busy   out  1      high in RUN and DONE
//   count  out  WIDTH  counter value, holds after a run until the next grant
//   done   out  2      one-cycle completion pulse for the owner
// ---------------------------------------------------------------------------
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic             last, last_n;   // index of the most recently served requester
    logic [1:0]       gnt_n;
    logic             busy_n;
    logic [WIDTH-1:0] count_n;
    logic [1:0]       done_n;
    logic             pick;           // requester chosen if a grant happens this edge

    // Under contention the requester that was not served last wins; a lone
    // request always wins. last resets to 1 so requester 0 wins first contention.
    always_comb begin
        if (req == 2'b11)
            pick = ~last;
        else
            pick = req[1];
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        busy_n  = busy;
        count_n = count;
        done_n  = 2'b00;
        len_n   = len_q;
        last_n  = last;

        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_n = S_RUN;
                    gnt_n   = pick ? 2'b10 : 2'b01;
                    busy_n  = 1'b1;
                    count_n = '0;
                    len_n   = pick ? len1 : len0;
                    last_n  = pick;
                end
            end
            S_RUN: begin
                // Terminal compare happens before increment, so count never
                // passes len_q and cannot wrap even at the all-ones length.
                if (count == len_q) begin
                    state_n = S_DONE;
                    done_n  = gnt;
                end else begin
                    count_n = count + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                gnt_n   = 2'b00;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                gnt_n   = 2'b00;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            count <= '0;
            done  <= 2'b00;
            len_q <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            count <= count_n;
            done  <= done_n;
            len_q <= len_n;
            last  <= last_n;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [1:0]       gnt;
        logic             busy;
        logic [WIDTH-1:0] count;
        logic [1:0]       done;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] len0 = '0;
    logic [WIDTH-1:0] len1 = '0;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [1:0]       done;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    string phase = "init";
    obs_t  sb[$];

    count_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Expected trace of one granted run of length len for requester i,
    // followed by the mandatory idle cycle.
    task automatic push_run(input int i, input int len);
        obs_t e;
        logic [1:0] oh;
        oh = (i == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k <= len; k++) begin
            e = '{gnt: oh, busy: 1'b1, count: WIDTH'(k), done: 2'b00};
            sb.push_back(e);
        end
        e = '{gnt: oh, busy: 1'b1, count: WIDTH'(len), done: oh};
        sb.push_back(e);
        e = '{gnt: 2'b00, busy: 1'b0, count: WIDTH'(len), done: 2'b00};
        sb.push_back(e);
    endtask

    task automatic push_zero();
        obs_t e;
        e = '{gnt: 2'b00, busy: 1'b0, count: '0, done: 2'b00};
        sb.push_back(e);
    endtask

    task automatic step_check(input int n);
        obs_t e;
        obs_t o;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            o = '{gnt: gnt, busy: busy, count: count, done: done};
            if (sb.size() == 0) begin
                chk($sformatf("%s.c%0d.sb_empty", phase, cyc), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s.c%0d", phase, cyc), 32'(o), 32'(e));
            end
        end
    endtask

    initial begin
        // 1: reset, then a single run of length 3
        phase = "reset";
        reset = 1'b1;
        repeat (4) push_zero();
        step_check(4);
        reset = 1'b0;
        phase = "single";
        len0 = 4'd3;
        req = 2'b01;
        push_run(0, 3);
        step_check(1);
        req = 2'b00;
        step_check(5);

        // 2: contention from fresh reset, grants alternate 0,1,0
        phase = "rst2";
        reset = 1'b1;
        push_zero();
        step_check(1);
        reset = 1'b0;
        phase = "contend";
        len0 = 4'd2;
        len1 = 4'd2;
        req = 2'b11;
        push_run(0, 2);
        push_run(1, 2);
        push_run(0, 2);
        step_check(15);
        req = 2'b00;

        // 3: zero-length run for requester 1
        phase = "zero";
        len1 = 4'd0;
        req = 2'b10;
        push_run(1, 0);
        step_check(1);
        req = 2'b00;
        step_check(2);

        // 4: max length, count must hold at 15 without wrapping
        phase = "max";
        len0 = 4'd15;
        req = 2'b01;
        push_run(0, 15);
        sb.push_back('{gnt: 2'b00, busy: 1'b0, count: 4'd15, done: 2'b00});
        step_check(1);
        req = 2'b00;
        step_check(18);

        // 5: reset at count=5, reset beats a simultaneous request
        phase = "midreset";
        len0 = 4'd9;
        req = 2'b01;
        for (int k = 0; k <= 5; k++)
            sb.push_back('{gnt: 2'b01, busy: 1'b1, count: WIDTH'(k), done: 2'b00});
        step_check(1);
        req = 2'b00;
        step_check(5);
        reset = 1'b1;
        req = 2'b11;
        push_zero();
        push_zero();
        step_check(2);
        reset = 1'b0;
        // after reset requester 0 wins; length change after grant is ignored
        phase = "postreset";
        len0 = 4'd1;
        push_run(0, 1);
        step_check(1);
        req = 2'b00;
        len0 = 4'd7;
        step_check(3);

        // 6: request dropped mid-run, run still completes
        phase = "drop";
        len0 = 4'd4;
        req = 2'b01;
        push_run(0, 4);
        step_check(2);
        req = 2'b00;
        step_check(5);

        // nothing should remain expected
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
